// File: rtl/dtcore32_wb_pkg.sv
// Shared writeback types and constants for the dtcore32 writeback arbiter.
package dtcore32_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // One register-file write: destination register and the value to write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/dtcore32_wb_fifo.sv
// Small circular FIFO holding long-latency writeback entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module dtcore32_wb_fifo
  import dtcore32_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  push_data,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries data only, so it is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dtcore32_wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with queued LSU results
// onto one register-file write port and tracks pending long-latency writes
// for decode hazard detection.
// Optional feature macro: DTCORE32_WB_FWD_EN adds forwarding from the
// registered write stage to the two decode sources.
module dtcore32_wb_arbiter
  import dtcore32_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_addr_i,
  input  logic [XLEN-1:0]       alu_wdata_i,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_addr_i,
  input  logic [XLEN-1:0]       lsu_wdata_i,
  output logic                  lsu_ready_o,
  input  logic                  pend_set_i,
  input  logic [REG_ADDR_W-1:0] pend_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  hazard_o,
  output logic                  regfile_wr_en_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       reg_wr_data_o
`ifdef DTCORE32_WB_FWD_EN
  ,
  output logic                  fwd_rs1_valid_o,
  output logic [XLEN-1:0]       fwd_rs1_data_o,
  output logic                  fwd_rs2_valid_o,
  output logic [XLEN-1:0]       fwd_rs2_data_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_entry_t              lsu_entry;
  wb_entry_t              fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_cnt;
  logic                   fifo_push;
  logic                   fifo_pop;

  logic                   sel_vld;
  wb_entry_t              sel_entry;

  logic                   vld_p0;
  logic [REG_ADDR_W-1:0]  rd_p0;
  logic signed [XLEN-1:0] data_p0;

  logic [XLEN-1:0]        pend_q;
  logic [XLEN-1:0]        pend_set_mask;
  logic [XLEN-1:0]        pend_clr_mask;
  logic                   haz_rs1;
  logic                   haz_rs2;

  assign lsu_entry   = '{rd: lsu_rd_addr_i, data: lsu_wdata_i};
  // Readiness comes from the registered count only, so a pop this cycle
  // cannot open a slot until the next one.
  assign lsu_ready_o = (fifo_cnt < CNT_W'(FIFO_DEPTH));
  assign fifo_push   = lsu_valid_i && !fifo_full;

  dtcore32_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (fifo_push),
    .push_data (lsu_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  // ALU has fixed priority; the FIFO head drains only on ALU-idle cycles.
  always_comb begin
    sel_vld   = 1'b0;
    sel_entry = '0;
    fifo_pop  = 1'b0;
    if (alu_valid_i) begin
      sel_vld   = 1'b1;
      sel_entry = '{rd: alu_rd_addr_i, data: alu_wdata_i};
    end else if (!fifo_empty) begin
      sel_vld   = 1'b1;
      sel_entry = fifo_head;
      fifo_pop  = 1'b1;
    end
  end

  // ---- stage p0: registered register-file write port ----
  // Writes to x0 are consumed but never enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      rd_p0   <= '0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= sel_vld && (sel_entry.rd != '0);
      if (sel_vld) begin
        rd_p0   <= sel_entry.rd;
        data_p0 <= sel_entry.data;
      end
    end
  end

  assign regfile_wr_en_o = vld_p0;
  assign rd_addr_o       = rd_p0;
  assign reg_wr_data_o   = data_p0;

  // Pending-mask update: a set beats a clear of the same bit in one cycle.
  always_comb begin
    pend_set_mask = '0;
    pend_clr_mask = '0;
    if (pend_set_i && (pend_rd_i != '0)) pend_set_mask[pend_rd_i] = 1'b1;
    if (fifo_pop) pend_clr_mask[fifo_head.rd] = 1'b1;
  end

  // Pending mask register, one bit per architectural register.
  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= (pend_q & ~pend_clr_mask) | pend_set_mask;
  end

`ifdef DTCORE32_WB_FWD_EN
  // Forward the write stage to a matching nonzero source and drop its hazard.
  always_comb begin
    fwd_rs1_valid_o = vld_p0 && (rs1_addr_i != '0) && (rd_p0 == rs1_addr_i);
    fwd_rs2_valid_o = vld_p0 && (rs2_addr_i != '0) && (rd_p0 == rs2_addr_i);
    fwd_rs1_data_o  = data_p0;
    fwd_rs2_data_o  = data_p0;
    haz_rs1 = (rs1_addr_i != '0) && pend_q[rs1_addr_i] && !fwd_rs1_valid_o;
    haz_rs2 = (rs2_addr_i != '0) && pend_q[rs2_addr_i] && !fwd_rs2_valid_o;
  end
`else
  // Decode hazard: any nonzero source with an outstanding long-latency write.
  always_comb begin
    haz_rs1 = (rs1_addr_i != '0) && pend_q[rs1_addr_i];
    haz_rs2 = (rs2_addr_i != '0) && pend_q[rs2_addr_i];
  end
`endif

  assign hazard_o = haz_rs1 || haz_rs2;

endmodule

// File: tb/tb_dtcore32_wb_arbiter.sv
// Self-checking bench for dtcore32_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_dtcore32_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        alu_valid_i = 1'b0;
  logic [4:0]  alu_rd_addr_i = '0;
  logic [31:0] alu_wdata_i = '0;
  logic        lsu_valid_i = 1'b0;
  logic [4:0]  lsu_rd_addr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic        lsu_ready_o;
  logic        pend_set_i = 1'b0;
  logic [4:0]  pend_rd_i = '0;
  logic [4:0]  rs1_addr_i = '0;
  logic [4:0]  rs2_addr_i = '0;
  logic        hazard_o;
  logic        regfile_wr_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] reg_wr_data_o;
`ifdef DTCORE32_WB_FWD_EN
  logic        fwd_rs1_valid_o;
  logic [31:0] fwd_rs1_data_o;
  logic        fwd_rs2_valid_o;
  logic [31:0] fwd_rs2_data_o;
`endif

  dtcore32_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .alu_valid_i     (alu_valid_i),
    .alu_rd_addr_i   (alu_rd_addr_i),
    .alu_wdata_i     (alu_wdata_i),
    .lsu_valid_i     (lsu_valid_i),
    .lsu_rd_addr_i   (lsu_rd_addr_i),
    .lsu_wdata_i     (lsu_wdata_i),
    .lsu_ready_o     (lsu_ready_o),
    .pend_set_i      (pend_set_i),
    .pend_rd_i       (pend_rd_i),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_addr_i      (rs2_addr_i),
    .hazard_o        (hazard_o),
    .regfile_wr_en_o (regfile_wr_en_o),
    .rd_addr_o       (rd_addr_o),
    .reg_wr_data_o   (reg_wr_data_o)
`ifdef DTCORE32_WB_FWD_EN
    ,
    .fwd_rs1_valid_o (fwd_rs1_valid_o),
    .fwd_rs1_data_o  (fwd_rs1_data_o),
    .fwd_rs2_valid_o (fwd_rs2_valid_o),
    .fwd_rs2_data_o  (fwd_rs2_data_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: queued LSU results, pending registers, and the
  // write that should currently be visible on the output port.
  logic [4:0]  mq_rd[$];
  logic [31:0] mq_data[$];
  bit          mdl_pend[32];
  bit          m_wr = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_data = '0;

  // Values seen just before the most recent active edge.
  logic        last_rdy;
  logic        last_haz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mdl_clear();
    mq_rd.delete();
    mq_data.delete();
    foreach (mdl_pend[i]) mdl_pend[i] = 1'b0;
    m_wr = 1'b0;
    m_rd = '0;
    m_data = '0;
  endtask

  // Apply one cycle of inputs, check combinational outputs before the edge,
  // advance the model, then check the registered write port after the edge.
  task automatic step(input bit r, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                      input bit ps, input logic [4:0] prd,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit rdy, hz, f1, f2;
    @(negedge clk_i);
    rst_i = r; alu_valid_i = av; alu_rd_addr_i = ard; alu_wdata_i = ad;
    lsu_valid_i = lv; lsu_rd_addr_i = lrd; lsu_wdata_i = ld;
    pend_set_i = ps; pend_rd_i = prd; rs1_addr_i = r1; rs2_addr_i = r2;
    #1;
    rdy = (mq_rd.size() < DEPTH);
    f1 = 1'b0;
    f2 = 1'b0;
`ifdef DTCORE32_WB_FWD_EN
    f1 = m_wr && (r1 != 0) && (m_rd == r1);
    f2 = m_wr && (r2 != 0) && (m_rd == r2);
    chk("fwd_rs1_valid", {31'd0, fwd_rs1_valid_o}, {31'd0, f1});
    chk("fwd_rs2_valid", {31'd0, fwd_rs2_valid_o}, {31'd0, f2});
    if (f1) chk("fwd_rs1_data", fwd_rs1_data_o, m_data);
    if (f2) chk("fwd_rs2_data", fwd_rs2_data_o, m_data);
`endif
    hz = ((r1 != 0) && mdl_pend[r1] && !f1) || ((r2 != 0) && mdl_pend[r2] && !f2);
    last_rdy = lsu_ready_o;
    last_haz = hazard_o;
    chk("lsu_ready", {31'd0, lsu_ready_o}, {31'd0, rdy});
    chk("hazard", {31'd0, hazard_o}, {31'd0, hz});
    if (r) begin
      mdl_clear();
    end else begin
      if (av) begin
        m_wr = (ard != 0); m_rd = ard; m_data = ad;
      end else if (mq_rd.size() > 0) begin
        m_rd = mq_rd.pop_front();
        m_data = mq_data.pop_front();
        m_wr = (m_rd != 0);
        mdl_pend[m_rd] = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      if (lv && rdy) begin
        mq_rd.push_back(lrd);
        mq_data.push_back(ld);
      end
      if (ps && prd != 0) mdl_pend[prd] = 1'b1;
    end
    @(posedge clk_i);
    #1;
    chk("wr_en", {31'd0, regfile_wr_en_o}, {31'd0, m_wr});
    if (m_wr || r) begin
      chk("rd_addr", {27'd0, rd_addr_o}, {27'd0, m_rd});
      chk("wr_data", reg_wr_data_o, m_data);
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  initial begin
    mdl_clear();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_wr_en", {31'd0, regfile_wr_en_o}, 32'd0);
    chk("rst_rd", {27'd0, rd_addr_o}, 32'd0);
    chk("rst_data", reg_wr_data_o, 32'd0);
    chk("rst_ready", {31'd0, lsu_ready_o}, 32'd1);
    chk("rst_hazard", {31'd0, hazard_o}, 32'd0);

    // ALU result appears one cycle after selection.
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_wr_en", {31'd0, regfile_wr_en_o}, 32'd1);
    chk("alu_rd", {27'd0, rd_addr_o}, 32'd5);
    chk("alu_data", reg_wr_data_o, 32'hDEADBEEF);
    idle(0, 0);

    // Pending register 7 hazards until its LSU result is written.
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(0, 0, 0, 0, 1, 7, 32'h12, 0, 0, 7, 0);
    chk("pend_haz_push", {31'd0, last_haz}, 32'd1);
    idle(7, 0);
    chk("pend_haz_sel", {31'd0, last_haz}, 32'd1);
    chk("lsu_wr_en", {31'd0, regfile_wr_en_o}, 32'd1);
    chk("lsu_rd", {27'd0, rd_addr_o}, 32'd7);
    chk("lsu_data", reg_wr_data_o, 32'h12);
    chk("pend_haz_clear", {31'd0, hazard_o}, 32'd0);
    idle(7, 0);

    // ALU busy six cycles while LSU tries five pushes; fifth is refused.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 5'(i + 1), 32'(i), (i < 5), 5'(10 + i), 32'h100 + 32'(i), 0, 0, 0, 0);
      if (i == 4) chk("full_ready", {31'd0, last_rdy}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      idle(0, 0);
      chk("drain_rd", {27'd0, rd_addr_o}, 32'(10 + k));
      chk("drain_data", reg_wr_data_o, 32'h100 + 32'(k));
    end
    idle(0, 0);
    chk("drain_done", {31'd0, regfile_wr_en_o}, 32'd0);

    // LSU write to x0 is consumed silently.
    step(0, 0, 0, 0, 1, 0, 32'hFF, 0, 0, 0, 0);
    idle(0, 0);
    chk("x0_wr_en", {31'd0, regfile_wr_en_o}, 32'd0);
    idle(0, 0);

    // Full FIFO with pending bits, then reset mid-operation.
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'(20 + i), 32'(i), 1, 5'(12 + i), 32'hA0 + 32'(i), 1, 5'(12 + i), 0, 0);
    idle(12, 13);
    chk("pre_rst_haz", {31'd0, last_haz}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 12, 13);
    idle(12, 13);
    chk("post_rst_ready", {31'd0, last_rdy}, 32'd1);
    chk("post_rst_haz", {31'd0, last_haz}, 32'd0);
    chk("post_rst_wr", {31'd0, regfile_wr_en_o}, 32'd0);

`ifdef DTCORE32_WB_FWD_EN
    // Forward the write stage to rs2 and mask its hazard.
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    step(0, 1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rs2_addr_i = 3;
    alu_valid_i = 1'b0;
    #1;
    chk("fwd2_valid", {31'd0, fwd_rs2_valid_o}, 32'd1);
    chk("fwd2_data", fwd_rs2_data_o, 32'h55);
    chk("fwd2_haz", {31'd0, hazard_o}, 32'd0);
    idle(0, 3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 97) == 0,
           ($urandom % 2) == 0, 5'($urandom_range(0, 7)), $urandom,
           ($urandom % 5) < 3, 5'($urandom_range(0, 7)), $urandom,
           ($urandom % 10) < 3, 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    repeat (DEPTH + 1) idle(0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule

// File: doc/dtcore32_wb_arbiter.md
DTCORE32_WB_ARBITER -- requirements
Module: dtcore32_wb_arbiter

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, the number of long-latency result entries (power of two, 2..16).
REQ-002 The module SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-004 The module SHALL have ports alu_valid_i / alu_rd_addr_i / alu_wdata_i, input, 1/5/32, single-cycle result, no backpressure.
REQ-005 The module SHALL have ports lsu_valid_i / lsu_rd_addr_i / lsu_wdata_i, input, 1/5/32, long-latency result; lsu_ready_o, output, 1.
REQ-006 The module SHALL have ports pend_set_i / pend_rd_i, input, 1/5, issue of a long-latency op targeting pend_rd_i.
REQ-007 The module SHALL have ports rs1_addr_i / rs2_addr_i, input, 5, decode-stage sources; hazard_o, output, 1.
REQ-008 The module SHALL have ports regfile_wr_en_o / rd_addr_o / reg_wr_data_o, output, 1/5/32, driving the register file write port.

Function
REQ-009 The module SHALL accept an LSU result on a cycle where lsu_valid_i and lsu_ready_o are both high, pushing it to a FIFO_DEPTH FIFO.
REQ-010 lsu_ready_o SHALL be high iff the registered FIFO count is below FIFO_DEPTH; a same-cycle pop SHALL NOT raise it.
REQ-011 Each cycle the arbiter SHALL select ALU when alu_valid_i is high, else the FIFO head when non-empty, else nothing.
REQ-012 The FIFO head SHALL pop only on a cycle it is selected; ALU always wins and the FIFO waits.
REQ-013 Write outputs SHALL be registered: the selected result appears on regfile_wr_en_o/rd_addr_o/reg_wr_data_o exactly one cycle after selection.
REQ-014 A selected result with rd = 0 SHALL be consumed (popped if FIFO) but SHALL drive regfile_wr_en_o low.
REQ-015 Push and pop in the same cycle SHALL leave count unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-016 A 32-bit pending mask SHALL set bit pend_rd_i on pend_set_i (ignored for x0) and clear bit rd when a FIFO entry for rd is selected.
REQ-017 Same-cycle set and clear of the same bit SHALL leave the bit set.
REQ-018 hazard_o SHALL be combinational: pending[rs1_addr_i] OR pending[rs2_addr_i], with address 0 never hazarding.
REQ-019 Overflow SHALL be impossible; lsu_valid_i while lsu_ready_o is low SHALL be ignored without state change.

Reset
REQ-020 Reset SHALL clear FIFO pointers, count, pending mask and output stage; after reset regfile_wr_en_o=0, rd_addr_o=0, reg_wr_data_o=0, lsu_ready_o=1, hazard_o=0.
REQ-021 Reset mid-operation SHALL discard all queued entries and pending bits with no write issued on the following cycle.

Configuration
REQ-022 With DTCORE32_WB_FWD_EN defined, outputs fwd_rs1_valid_o/fwd_rs1_data_o and fwd_rs2_valid_o/fwd_rs2_data_o (1/32) SHALL forward the output stage when regfile_wr_en_o is high and rd_addr_o equals a nonzero source, and hazard_o SHALL ignore that source's pending bit.
REQ-023 Without DTCORE32_WB_FWD_EN, the forwarding ports SHALL not exist and hazard_o SHALL follow REQ-018 exactly.

Structure
REQ-024 A shared package SHALL hold the wb entry typedef (rd 5 bits, data 32 bits) and constants REG_ADDR_W=5, XLEN=32.
REQ-025 The FIFO SHALL be a sub-module dtcore32_wb_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-026 Reset, then ALU valid rd=5 data=0xDEADBEEF -> next cycle wr_en=1, rd=5, data=0xDEADBEEF.
REQ-027 pend_set rd=7, then LSU push rd=7 data=0x12 with ALU idle -> hazard_o high for rs1=7 until write cycle, wr_en=1 rd=7 data=0x12, hazard_o low after.
REQ-028 ALU valid for 6 consecutive cycles while 4 LSU pushes -> 5th push sees lsu_ready_o=0; LSU writes drain in order after ALU stops.
REQ-029 LSU push rd=0 data=0xFF -> entry popped, wr_en stays 0, count returns to 0.
REQ-030 FIFO full plus reset asserted -> next cycle count=0, lsu_ready_o=1, hazard_o=0, no write.
REQ-031 With DTCORE32_WB_FWD_EN, output stage rd=3 data=0x55 and rs2=3 -> fwd_rs2_valid_o=1, fwd_rs2_data_o=0x55, hazard_o=0.
